// File: rtl/am_mod_scheduler_pkg.sv
// Shared types and defaults for the AM modulator parameter scheduler.
// Widths here match the modulator datapath.
package am_mod_scheduler_pkg;

  localparam int unsigned DEF_PHASE_WIDTH = 32;
  localparam int unsigned DEF_DEEP_WIDTH  = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RAMP_DOWN = 3'd1,
    S_SWITCH    = 3'd2,
    S_SETTLE    = 3'd3,
    S_RAMP_UP   = 3'd4
  } state_t;

  // A zero step would never reach the target, so treat it as one.
  function automatic int unsigned clamp_step(int unsigned s);
    return (s == 0) ? 1 : s;
  endfunction

endpackage

// File: rtl/am_deep_ramp.sv
// Saturating one-step move of a depth value toward a target.
// Arithmetic is one bit wider so an upward step cannot wrap.
module am_deep_ramp #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  input  logic [W:0]   step,
  output logic [W-1:0] next,
  output logic         at_target
);

  logic [W:0] w_cur;
  logic [W:0] w_tgt;
  logic [W:0] w_up;
  logic [W:0] w_dn;

  assign w_cur = {1'b0, cur};
  assign w_tgt = {1'b0, tgt};
  assign w_up  = w_cur + step;
  assign w_dn  = w_cur - step;

  // Step toward the target, landing exactly on it when within one step.
  always_comb begin
    next = tgt;
    if (w_cur < w_tgt) begin
      if (w_up < w_tgt) next = w_up[W-1:0];
    end else if (w_cur > w_tgt) begin
      if ((w_cur - w_tgt) > step) next = w_dn[W-1:0];
    end
    at_target = (next == tgt);
  end

endmodule

// File: rtl/am_mod_scheduler.sv
// Sequences carrier/depth changes for the AM modulator.
// Carrier switches only happen with depth ramped to zero.
module am_mod_scheduler
  import am_mod_scheduler_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH = DEF_PHASE_WIDTH,
  parameter int unsigned DEEP_WIDTH  = DEF_DEEP_WIDTH,
  parameter int unsigned RAMP_STEP   = 256,
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic                   clk_in,
  input  logic                   RST,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [PHASE_WIDTH-1:0] cfg_fre,
  input  logic [DEEP_WIDTH-1:0]  cfg_deep,
  input  logic                   cfg_mute,
  output logic [PHASE_WIDTH-1:0] center_fre,
  output logic [DEEP_WIDTH-1:0]  modulate_deep,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned STEP_C = clamp_step(RAMP_STEP);
  localparam int unsigned CW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES + 1) : 1;

  state_t                 r_state;
  logic [PHASE_WIDTH-1:0] r_fre;
  logic [DEEP_WIDTH-1:0]  r_deep;
  logic [PHASE_WIDTH-1:0] r_tgt_fre;
  logic [DEEP_WIDTH-1:0]  r_tgt_deep;
  logic [CW-1:0]          r_cnt;
  logic                   r_done;

  logic [DEEP_WIDTH:0]    w_step;
  logic [DEEP_WIDTH-1:0]  w_ramp_tgt;
  logic [DEEP_WIDTH-1:0]  w_next;
  logic                   w_at;

  assign w_step     = (DEEP_WIDTH + 1)'(STEP_C);
  assign w_ramp_tgt = (r_state == S_RAMP_DOWN) ? '0 : r_tgt_deep;

  am_deep_ramp #(
    .W (DEEP_WIDTH)
  ) u_ramp (
    .cur       (r_deep),
    .tgt       (w_ramp_tgt),
    .step      (w_step),
    .next      (w_next),
    .at_target (w_at)
  );

  assign center_fre    = r_fre;
  assign modulate_deep = r_deep;
  assign done          = r_done;
  assign cfg_ready     = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);

  // Sequencer: accept, ramp down, switch carrier, settle, ramp up.
  always_ff @(posedge clk_in) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_fre      <= '0;
      r_deep     <= '0;
      r_tgt_fre  <= '0;
      r_tgt_deep <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (cfg_valid) begin
            r_tgt_fre  <= cfg_fre;
            r_tgt_deep <= cfg_mute ? '0 : cfg_deep;
            r_state    <= (cfg_fre == r_fre) ? S_RAMP_UP
                                             : S_RAMP_DOWN;
          end
        end
        S_RAMP_DOWN: begin
          r_deep <= w_next;
          if (w_at) r_state <= S_SWITCH;
        end
        S_SWITCH: begin
          r_fre   <= r_tgt_fre;
          r_cnt   <= CW'(HOLD_CYCLES);
          r_state <= (HOLD_CYCLES == 0) ? S_RAMP_UP : S_SETTLE;
        end
        S_SETTLE: begin
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt <= CW'(1)) r_state <= S_RAMP_UP;
        end
        S_RAMP_UP: begin
          r_deep <= w_next;
          if (w_at) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_am_mod_scheduler.sv
// Bench for am_mod_scheduler: per-request expected-output
// schedule model, every-cycle compare, literal trace checks.
module tb_am_mod_scheduler;

  localparam int S = 256;
  localparam int H = 4;

  logic        clk_in = 1'b0;
  logic        RST = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [31:0] cfg_fre = '0;
  logic [15:0] cfg_deep = '0;
  logic        cfg_mute = 1'b0;
  logic [31:0] center_fre;
  logic [15:0] modulate_deep;
  logic        busy;
  logic        done;

  am_mod_scheduler #(
    .PHASE_WIDTH (32),
    .DEEP_WIDTH  (16),
    .RAMP_STEP   (S),
    .HOLD_CYCLES (H)
  ) dut (
    .clk_in        (clk_in),
    .RST           (RST),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_fre       (cfg_fre),
    .cfg_deep      (cfg_deep),
    .cfg_mute      (cfg_mute),
    .center_fre    (center_fre),
    .modulate_deep (modulate_deep),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] fre;
    int          deep;
    bit          busy;
    bit          done;
    bit          settle;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  bit          m_ok = 0;
  logic [31:0] m_fre = '0;
  int          m_deep = 0;
  int          n_accept = 0;

  int          checks = 0;
  int          failures = 0;
  int          trace[$];
  logic [31:0] ftrace[$];
  int          ex[$];

  function automatic void chk(string nm, logic [63:0] act,
                              logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, req, $time);
    end
  endfunction

  function automatic exp_t mk(logic [31:0] f, int d, bit b,
                              bit dn, bit st);
    exp_t x;
    x.fre = f;
    x.deep = d;
    x.busy = b;
    x.done = dn;
    x.settle = st;
    return x;
  endfunction

  // Lay out the whole expected output schedule of one request.
  function automatic void build(logic [31:0] nf, int t);
    int d = m_deep;
    logic [31:0] f = m_fre;
    q.push_back(mk(f, d, 1, 0, 0));
    if (nf != f) begin
      do begin
        d = (d > S) ? d - S : 0;
        q.push_back(mk(f, d, 1, 0, 0));
      end while (d != 0);
      f = nf;
      q.push_back(mk(f, 0, 1, 0, 0));
      for (int i = 0; i < H; i++) q.push_back(mk(f, 0, 1, 0, 1));
    end
    do begin
      if (d < t) d = (d + S > t) ? t : d + S;
      else if (d > t) d = (d - S < t) ? t : d - S;
      q.push_back(mk(f, d, d != t, d == t, 0));
    end while (d != t);
  endfunction

  // Model: expected outputs after each rising edge.
  always @(posedge clk_in) begin
    if (!RST) begin
      q.delete();
      e = mk('0, 0, 0, 0, 0);
    end else if (q.size() != 0) begin
      e = q.pop_front();
    end else if (cfg_valid) begin
      build(cfg_fre, cfg_mute ? 0 : int'(cfg_deep));
      n_accept++;
      e = q.pop_front();
    end else begin
      e = mk(m_fre, m_deep, 0, 0, 0);
    end
    m_fre = e.fre;
    m_deep = e.deep;
    m_ok = 1;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk_in) begin
    if (m_ok) begin
      chk("center_fre", 64'(center_fre), 64'(e.fre));
      chk("modulate_deep", 64'(modulate_deep), 64'(e.deep));
      chk("busy", 64'(busy), 64'(e.busy));
      chk("done", 64'(done), 64'(e.done));
      chk("cfg_ready", 64'(cfg_ready), 64'(!e.busy));
      if (e.busy || e.done) begin
        trace.push_back(int'(modulate_deep));
        ftrace.push_back(center_fre);
      end
    end
  end

  task automatic wait_accept(int a0);
    int i = 0;
    while (n_accept == a0 && i < 100) begin
      @(posedge clk_in);
      #1;
      i++;
    end
    if (n_accept == a0) chk("accept_timeout", 1, 0);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done();
    int i = 0;
    do begin
      @(negedge clk_in);
      #1;
      i++;
    end while (!e.done && i < 2000);
    if (!e.done) chk("done_timeout", 1, 0);
  endtask

  task automatic req(logic [31:0] f, logic [15:0] d, logic m);
    int a0 = n_accept;
    @(posedge clk_in);
    #2;
    trace.delete();
    ftrace.delete();
    cfg_valid = 1'b1;
    cfg_fre = f;
    cfg_deep = d;
    cfg_mute = m;
    wait_accept(a0);
    wait_done();
  endtask

  task automatic check_trace(string nm);
    chk({nm, "_len"}, 64'(trace.size()), 64'(ex.size()));
    for (int i = 0; i < ex.size() && i < trace.size(); i++)
      chk(nm, 64'(trace[i]), 64'(ex[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    int i;
    RST = 1'b0;
    repeat (2) @(posedge clk_in);
    #2;
    RST = 1'b1;
    @(negedge clk_in);
    chk("rst_fre", 64'(center_fre), 64'h0);
    chk("rst_deep", 64'(modulate_deep), 64'h0);
    chk("rst_ready", 64'(cfg_ready), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);

    req(32'h0, 16'd1000, 1'b0);
    ex = '{0, 256, 512, 768, 1000};
    check_trace("same_fre");
    chk("same_fre_fre", 64'(center_fre), 64'h0);

    req(32'h0100_0000, 16'd1000, 1'b0);
    req(32'h0200_0000, 16'd600, 1'b0);
    ex = '{1000, 744, 488, 232, 0, 0, 0, 0, 0, 0, 256, 512, 600};
    check_trace("fre_chg");
    if (ftrace.size() > 5) begin
      chk("fre_before_sw", 64'(ftrace[4]), 64'h0100_0000);
      chk("fre_after_sw", 64'(ftrace[5]), 64'h0200_0000);
    end else begin
      chk("fre_trace_len", 64'(ftrace.size()), 64'd13);
    end

    req(32'h0200_0000, 16'hFFFF, 1'b1);
    ex = '{600, 344, 88, 0};
    check_trace("mute");
    chk("mute_fre", 64'(center_fre), 64'h0200_0000);

    req(32'h0200_0000, 16'hFF80, 1'b0);
    req(32'h0200_0000, 16'hFFFF, 1'b0);
    ex = '{16'hFF80, 16'hFFFF};
    check_trace("saturate");

    a0 = n_accept;
    @(posedge clk_in);
    #2;
    cfg_valid = 1'b1;
    cfg_fre = 32'h0300_0000;
    cfg_deep = 16'd500;
    cfg_mute = 1'b0;
    wait_accept(a0);
    i = 0;
    do begin
      @(negedge clk_in);
      #1;
      i++;
    end while (!e.settle && i < 1000);
    if (!e.settle) chk("settle_timeout", 1, 0);
    RST = 1'b0;
    cfg_valid = 1'b1;
    cfg_fre = 32'h0400_0000;
    cfg_deep = 16'd300;
    a0 = n_accept;
    @(posedge clk_in);
    #1;
    RST = 1'b1;
    trace.delete();
    ftrace.delete();
    @(negedge clk_in);
    chk("midrst_fre", 64'(center_fre), 64'h0);
    chk("midrst_deep", 64'(modulate_deep), 64'h0);
    chk("midrst_ready", 64'(cfg_ready), 64'h1);
    chk("midrst_busy", 64'(busy), 64'h0);
    wait_accept(a0);
    wait_done();
    ex = '{0, 0, 0, 0, 0, 0, 0, 256, 300};
    check_trace("post_rst");
    chk("post_rst_fre", 64'(center_fre), 64'h0400_0000);

    repeat (3) @(negedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
